// File: rtl/smem_pkg.sv
// Shared definitions for the backward-stage store unit: sizes, drain FSM
// encoding and the four-field entry layout held in both buffers.
package smem_pkg;

   localparam int DEPTH   = 128;
   localparam int ADDR_W  = $clog2(DEPTH);
   localparam int DATA_W  = 64;
   localparam int ENTRY_W = 4 * DATA_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   // One buffer entry; x0 occupies the most significant bits of the packed word.
   typedef struct packed {
      logic [DATA_W-1:0] x0;
      logic [DATA_W-1:0] x1;
      logic [DATA_W-1:0] x2;
      logic [DATA_W-1:0] info;
   } entry_t;

   // Bundle four fields into one entry.
   function automatic entry_t make_entry(input logic [DATA_W-1:0] x0,
                                         input logic [DATA_W-1:0] x1,
                                         input logic [DATA_W-1:0] x2,
                                         input logic [DATA_W-1:0] info);
      entry_t e;
      e.x0   = x0;
      e.x1   = x1;
      e.x2   = x2;
      e.info = info;
      return e;
   endfunction

endpackage

// File: rtl/sp_ram_1r1w.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output. BYPASS=1 makes a same-cycle write to the read address visible on
// the read data (write-first); BYPASS=0 returns the old contents.
module sp_ram_1r1w #(
   parameter int WIDTH  = 256,
   parameter int DEPTH  = 128,
   parameter int AW     = 7,
   parameter bit BYPASS = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             re,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Storage array: contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port; holds its value while re is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (re) begin
         if (BYPASS && we && (wr_addr == rd_addr)) begin
            rd_data_q <= wr_data;
         end else begin
            rd_data_q <= mem[rd_addr];
         end
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/bck_store_unit.sv
// Store unit behind the backward control stage. CURR holds the current
// interval list with a write-first read-back port; MEM collects SMEM results
// and is streamed out over valid/ready once drain_start arrives.
module bck_store_unit
   import smem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              store_valid_curr,
   input  logic [ADDR_W-1:0] curr_x_addr,
   input  logic [DATA_W-1:0] curr_x_0,
   input  logic [DATA_W-1:0] curr_x_1,
   input  logic [DATA_W-1:0] curr_x_2,
   input  logic [DATA_W-1:0] curr_x_info,
   input  logic              store_valid_mem,
   input  logic [ADDR_W-1:0] mem_x_addr,
   input  logic [DATA_W-1:0] mem_x_0,
   input  logic [DATA_W-1:0] mem_x_1,
   input  logic [DATA_W-1:0] mem_x_2,
   input  logic [DATA_W-1:0] mem_x_info,
   input  logic [ADDR_W-1:0] current_rd_addr,
   output logic [DATA_W-1:0] rd_x_0,
   output logic [DATA_W-1:0] rd_x_1,
   output logic [DATA_W-1:0] rd_x_2,
   output logic [DATA_W-1:0] rd_x_info,
   input  logic              drain_start,
   input  logic [ADDR_W-1:0] drain_count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_x_0,
   output logic [DATA_W-1:0] out_x_1,
   output logic [DATA_W-1:0] out_x_2,
   output logic [DATA_W-1:0] out_x_info,
   output logic              out_last,
   output logic              drain_busy,
   output logic              drain_done,
   output logic              err_wr_drain
);

   entry_t curr_wr_entry;
   entry_t curr_rd_entry;
   entry_t mem_wr_entry;
   entry_t mem_rd_entry;
   logic   mem_we;
   logic   mem_re;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] out_idx_q, out_idx_d;
   logic              s1_valid_q, s1_valid_d;
   logic              out_valid_q, out_valid_d;
   logic              err_q, err_d;
   entry_t            out_q, out_d;

   logic handshake;
   logic s2_load;
   logic issue;
   logic at_last;

   assign curr_wr_entry = make_entry(curr_x_0, curr_x_1, curr_x_2, curr_x_info);
   assign mem_wr_entry  = make_entry(mem_x_0, mem_x_1, mem_x_2, mem_x_info);

   // MEM is frozen while it is being streamed out; such writes only raise the error flag.
   assign mem_we = store_valid_mem && (state_q != S_DRAIN);

   sp_ram_1r1w #(
      .WIDTH  (ENTRY_W),
      .DEPTH  (DEPTH),
      .AW     (ADDR_W),
      .BYPASS (1'b1)
   ) u_curr_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (store_valid_curr),
      .wr_addr (curr_x_addr),
      .wr_data (curr_wr_entry),
      .re      (1'b1),
      .rd_addr (current_rd_addr),
      .rd_data (curr_rd_entry)
   );

   sp_ram_1r1w #(
      .WIDTH  (ENTRY_W),
      .DEPTH  (DEPTH),
      .AW     (ADDR_W),
      .BYPASS (1'b0)
   ) u_mem_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (mem_we),
      .wr_addr (mem_x_addr),
      .wr_data (mem_wr_entry),
      .re      (mem_re),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rd_entry)
   );

   // Two-stage drain pipe: the RAM read register is stage 1, out_q is stage 2.
   // A new read is issued whenever stage 1 is empty or is moving into stage 2,
   // which keeps one entry per cycle flowing while out_ready stays high.
   assign handshake = out_valid_q && out_ready;
   assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);
   assign issue     = (state_q == S_DRAIN) && (rd_ptr_q < cnt_q) && (!s1_valid_q || s2_load);
   assign at_last   = (out_idx_q == (cnt_q - ADDR_W'(1)));
   assign mem_re    = issue;

   // Next-state logic for the drain FSM, read pointer and output register.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_ptr_d    = rd_ptr_q;
      out_idx_d   = out_idx_q;
      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      err_d       = err_q || (store_valid_mem && (state_q == S_DRAIN));
      case (state_q)
         S_IDLE: begin
            if (drain_start) begin
               cnt_d       = drain_count;
               rd_ptr_d    = '0;
               out_idx_d   = '0;
               s1_valid_d  = 1'b0;
               out_valid_d = 1'b0;
               state_d     = (drain_count == '0) ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (issue) begin
               rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            s1_valid_d  = issue || (s1_valid_q && !s2_load);
            out_valid_d = s2_load || (out_valid_q && !out_ready);
            if (s2_load) begin
               out_d = mem_rd_entry;
            end
            if (handshake) begin
               out_idx_d = out_idx_q + ADDR_W'(1);
               if (at_last) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and output registers; reset aborts any drain in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rd_ptr_q    <= '0;
         out_idx_q   <= '0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         out_idx_q   <= out_idx_d;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         err_q       <= err_d;
      end
   end

   assign rd_x_0       = curr_rd_entry.x0;
   assign rd_x_1       = curr_rd_entry.x1;
   assign rd_x_2       = curr_rd_entry.x2;
   assign rd_x_info    = curr_rd_entry.info;

   assign out_valid    = out_valid_q;
   assign out_x_0      = out_q.x0;
   assign out_x_1      = out_q.x1;
   assign out_x_2      = out_q.x2;
   assign out_x_info   = out_q.info;
   assign out_last     = out_valid_q && at_last;
   assign drain_busy   = (state_q == S_DRAIN);
   assign drain_done   = (state_q == S_DONE);
   assign err_wr_drain = err_q;

endmodule

// File: tb/tb_bck_store_unit.sv
// Directed bench for bck_store_unit: CURR read-back, write-first bypass,
// MEM drain with and without back-pressure, empty drain, write-during-drain
// error and reset in the middle of a drain.
module tb_bck_store_unit;
   import smem_pkg::*;

   logic              clk;
   logic              rst;
   logic              store_valid_curr;
   logic [ADDR_W-1:0] curr_x_addr;
   logic [DATA_W-1:0] curr_x_0, curr_x_1, curr_x_2, curr_x_info;
   logic              store_valid_mem;
   logic [ADDR_W-1:0] mem_x_addr;
   logic [DATA_W-1:0] mem_x_0, mem_x_1, mem_x_2, mem_x_info;
   logic [ADDR_W-1:0] current_rd_addr;
   logic [DATA_W-1:0] rd_x_0, rd_x_1, rd_x_2, rd_x_info;
   logic              drain_start;
   logic [ADDR_W-1:0] drain_count;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_x_0, out_x_1, out_x_2, out_x_info;
   logic              out_last;
   logic              drain_busy;
   logic              drain_done;
   logic              err_wr_drain;

   int checks   = 0;
   int failures = 0;

   bck_store_unit dut (
      .clk              (clk),
      .rst              (rst),
      .store_valid_curr (store_valid_curr),
      .curr_x_addr      (curr_x_addr),
      .curr_x_0         (curr_x_0),
      .curr_x_1         (curr_x_1),
      .curr_x_2         (curr_x_2),
      .curr_x_info      (curr_x_info),
      .store_valid_mem  (store_valid_mem),
      .mem_x_addr       (mem_x_addr),
      .mem_x_0          (mem_x_0),
      .mem_x_1          (mem_x_1),
      .mem_x_2          (mem_x_2),
      .mem_x_info       (mem_x_info),
      .current_rd_addr  (current_rd_addr),
      .rd_x_0           (rd_x_0),
      .rd_x_1           (rd_x_1),
      .rd_x_2           (rd_x_2),
      .rd_x_info        (rd_x_info),
      .drain_start      (drain_start),
      .drain_count      (drain_count),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_x_0          (out_x_0),
      .out_x_1          (out_x_1),
      .out_x_2          (out_x_2),
      .out_x_info       (out_x_info),
      .out_last         (out_last),
      .drain_busy       (drain_busy),
      .drain_done       (drain_done),
      .err_wr_drain     (err_wr_drain)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mem_write(input logic [ADDR_W-1:0] a, input logic [63:0] x0, input logic [63:0] x2);
      store_valid_mem = 1'b1;
      mem_x_addr      = a;
      mem_x_0         = x0;
      mem_x_1         = 64'd0;
      mem_x_2         = x2;
      mem_x_info      = 64'd0;
      tick();
      store_valid_mem = 1'b0;
   endtask

   logic [63:0] exp_x2 [3];
   logic [63:0] held;
   logic        stalled;
   logic        done_seen;
   int          hs;

   initial begin
      exp_x2[0] = 64'd10;
      exp_x2[1] = 64'd20;
      exp_x2[2] = 64'd30;

      rst = 1'b1;
      store_valid_curr = 1'b0; curr_x_addr = '0;
      curr_x_0 = '0; curr_x_1 = '0; curr_x_2 = '0; curr_x_info = '0;
      store_valid_mem = 1'b0; mem_x_addr = '0;
      mem_x_0 = '0; mem_x_1 = '0; mem_x_2 = '0; mem_x_info = '0;
      current_rd_addr = '0;
      drain_start = 1'b0; drain_count = '0; out_ready = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_rd_x_0",     rd_x_0,              64'd0);
      check("rst_out_valid",  64'(out_valid),      64'd0);
      check("rst_drain_busy", 64'(drain_busy),     64'd0);
      check("rst_drain_done", 64'(drain_done),     64'd0);
      check("rst_err",        64'(err_wr_drain),   64'd0);
      check("rst_out_last",   64'(out_last),       64'd0);
      rst = 1'b0;
      tick();

      // 1: CURR write then read back
      store_valid_curr = 1'b1; curr_x_addr = 7'd5;
      curr_x_0 = 64'd1; curr_x_1 = 64'd2; curr_x_2 = 64'd3; curr_x_info = 64'd4;
      tick();
      store_valid_curr = 1'b0;
      current_rd_addr = 7'd5;
      tick();
      check("t1_rd_x_0",    rd_x_0,    64'd1);
      check("t1_rd_x_1",    rd_x_1,    64'd2);
      check("t1_rd_x_2",    rd_x_2,    64'd3);
      check("t1_rd_x_info", rd_x_info, 64'd4);

      // 2: same-cycle write and read of addr 9 returns the new data
      store_valid_curr = 1'b1; curr_x_addr = 7'd9;
      curr_x_0 = 64'hAAAA_AAAA_AAAA_AAAA; curr_x_1 = 64'd7; curr_x_2 = 64'd8; curr_x_info = 64'd9;
      current_rd_addr = 7'd9;
      tick();
      store_valid_curr = 1'b0;
      check("t2_bypass_x0", rd_x_0, 64'hAAAA_AAAA_AAAA_AAAA);
      check("t2_bypass_x1", rd_x_1, 64'd7);

      // 3: drain three entries with out_ready held high
      mem_write(7'd0, 64'd100, 64'd10);
      mem_write(7'd1, 64'd101, 64'd20);
      mem_write(7'd2, 64'd102, 64'd30);
      out_ready = 1'b1; drain_start = 1'b1; drain_count = 7'd3;
      tick();
      drain_start = 1'b0;
      check("t3_busy",       64'(drain_busy), 64'd1);
      check("t3_valid_e0",   64'(out_valid),  64'd0);
      tick();
      check("t3_valid_e1",   64'(out_valid),  64'd0);
      tick();
      check("t3_valid_0",    64'(out_valid),  64'd1);
      check("t3_x2_0",       out_x_2,         64'd10);
      check("t3_x0_0",       out_x_0,         64'd100);
      check("t3_last_0",     64'(out_last),   64'd0);
      tick();
      check("t3_x2_1",       out_x_2,         64'd20);
      check("t3_last_1",     64'(out_last),   64'd0);
      tick();
      check("t3_x2_2",       out_x_2,         64'd30);
      check("t3_last_2",     64'(out_last),   64'd1);
      tick();
      check("t3_valid_end",  64'(out_valid),  64'd0);
      check("t3_done",       64'(drain_done), 64'd1);
      check("t3_busy_end",   64'(drain_busy), 64'd0);
      tick();
      check("t3_done_pulse", 64'(drain_done), 64'd0);

      // 4: drain with out_ready toggling
      out_ready = 1'b0; drain_start = 1'b1; drain_count = 7'd3;
      tick();
      drain_start = 1'b0;
      hs = 0; stalled = 1'b0; done_seen = 1'b0; held = '0;
      for (int c = 0; c < 40 && !done_seen; c++) begin
         out_ready = c[0];
         if (stalled) begin
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_hold_data",  out_x_2,        held);
         end
         if (out_valid && out_ready) begin
            if (hs < 3) begin
               check("t4_data", out_x_2,        exp_x2[hs]);
               check("t4_last", 64'(out_last), 64'(hs == 2));
            end
            hs++;
            stalled = 1'b0;
         end else if (out_valid) begin
            stalled = 1'b1;
            held    = out_x_2;
         end else begin
            stalled = 1'b0;
         end
         tick();
         if (drain_done) done_seen = 1'b1;
      end
      check("t4_done_seen", 64'(done_seen), 64'd1);
      check("t4_handshakes", 64'(hs), 64'd3);
      out_ready = 1'b0;
      tick();

      // 5: empty drain
      drain_start = 1'b1; drain_count = 7'd0;
      tick();
      drain_start = 1'b0;
      check("t5_done",    64'(drain_done), 64'd1);
      check("t5_valid",   64'(out_valid),  64'd0);
      check("t5_busy",    64'(drain_busy), 64'd0);
      tick();
      check("t5_done_clr", 64'(drain_done), 64'd0);
      check("t5_valid2",   64'(out_valid),  64'd0);

      // 6a: MEM write during drain is dropped and flagged
      out_ready = 1'b0; drain_start = 1'b1; drain_count = 7'd3;
      tick();
      drain_start = 1'b0;
      check("t6_err_before", 64'(err_wr_drain), 64'd0);
      mem_write(7'd1, 64'd999, 64'd99);
      check("t6_err_set", 64'(err_wr_drain), 64'd1);
      check("t6_busy",    64'(drain_busy),   64'd1);
      tick();
      check("t6_x2_0", out_x_2, 64'd10);
      out_ready = 1'b1;
      tick();
      check("t6_x2_1_unchanged", out_x_2, 64'd20);
      check("t6_x0_1_unchanged", out_x_0, 64'd101);
      tick();
      check("t6_x2_2", out_x_2, 64'd30);
      tick();
      check("t6_done",       64'(drain_done),   64'd1);
      check("t6_err_sticky", 64'(err_wr_drain), 64'd1);
      tick();

      // 6b: reset in the middle of a drain
      out_ready = 1'b0; drain_start = 1'b1; drain_count = 7'd3;
      tick();
      drain_start = 1'b0;
      tick();
      tick();
      check("t6_mid_valid", 64'(out_valid), 64'd1);
      rst = 1'b1;
      tick();
      check("t6_rst_valid", 64'(out_valid),    64'd0);
      check("t6_rst_busy",  64'(drain_busy),   64'd0);
      check("t6_rst_err",   64'(err_wr_drain), 64'd0);
      check("t6_rst_done",  64'(drain_done),   64'd0);
      rst = 1'b0;
      tick();
      check("t6_no_done", 64'(drain_done), 64'd0);
      check("t6_idle",    64'(drain_busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
